// File: rtl/imu_spi_sched.sv
// Byte-level sequencer for the IMU SPI link: power-up wait, optional config writes
// (define IMU_CFG_EN), then one burst-read frame of 16-bit words per timer tick.
module imu_spi_sched #(
    parameter int         NUM_WORDS = 3,
    parameter logic [7:0] BASE_ADDR = 8'h3B,
    parameter int         INIT_WAIT = 50000,
    parameter int         CS_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    output logic        spi_start,
    output logic [7:0]  spi_data_in,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [7:0]  spi_data_out,
    output logic        imu_ss_n,
    output logic [15:0] sample_data,
    output logic [3:0]  sample_idx,
    output logic        sample_valid,
    output logic        frame_done,
    output logic        overrun,
    output logic        ready
);

    localparam int         WAIT_MAX  = (INIT_WAIT > CS_GAP) ? INIT_WAIT : CS_GAP;
    localparam int         CW        = $clog2(WAIT_MAX + 1);
    localparam logic [4:0] LAST_BYTE = 5'(2 * NUM_WORDS - 1);

    if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_num_words
        $error("imu_spi_sched: NUM_WORDS must be within 1..16");
    end

    typedef enum logic [2:0] {
        RESET_WAIT, CFG_ADDR, CFG_DATA, CFG_GAP, IDLE, RD_ADDR, RD_BYTE, RD_GAP
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    byte_cnt;
    logic [7:0]    hi_byte;
    logic          issued;
    logic          wait_done;
    logic [7:0]    tx_byte;
    logic          byte_state;
    logic          byte_done;
    logic          issue;

`ifdef IMU_CFG_EN
    // {register address, value}; entry 0 is the device reset and is followed by INIT_WAIT.
    localparam logic [15:0] CFG_TABLE [4] = '{16'h6B80, 16'h6B01, 16'h6A10, 16'h1A03};
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_word;
`endif

    assign byte_state = state inside {CFG_ADDR, CFG_DATA, RD_ADDR, RD_BYTE};
    // Completion strobes only count against a byte this block actually started.
    assign byte_done  = spi_new_data && issued;
    assign issue      = byte_state && !issued && !spi_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (!rst_n) state <= RESET_WAIT;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: all combinational outputs get a default first so no path infers a latch.
        next_state = state;
        tx_byte    = 8'hFF;
        wait_done  = 1'b0;
`ifdef IMU_CFG_EN
        cfg_word   = CFG_TABLE[cfg_idx];
`endif
        case (state)
            RESET_WAIT: begin
                wait_done = (wait_cnt == CW'(INIT_WAIT));
                if (wait_done) begin
`ifdef IMU_CFG_EN
                    next_state = CFG_ADDR;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef IMU_CFG_EN
            CFG_ADDR: begin
                tx_byte = cfg_word[15:8] & 8'h7F;
                if (byte_done) next_state = CFG_DATA;
            end
            CFG_DATA: begin
                tx_byte = cfg_word[7:0];
                if (byte_done) next_state = CFG_GAP;
            end
            CFG_GAP: begin
                if (cfg_idx == 2'd0) wait_done = (wait_cnt == CW'(INIT_WAIT - 1));
                else                 wait_done = (wait_cnt == CW'(CS_GAP - 1));
                if (wait_done) begin
                    if (cfg_idx == 2'd3) next_state = IDLE;
                    else                 next_state = CFG_ADDR;
                end
            end
`endif
            IDLE: begin
                if (tick) next_state = RD_ADDR;
            end
            RD_ADDR: begin
                tx_byte = 8'h80 | BASE_ADDR;
                if (byte_done) next_state = RD_BYTE;
            end
            RD_BYTE: begin
                tx_byte = 8'hFF;
                if (byte_done && byte_cnt == LAST_BYTE) next_state = RD_GAP;
            end
            RD_GAP: begin
                wait_done = (wait_cnt == CW'(CS_GAP - 1));
                if (wait_done) next_state = IDLE;
            end
            default: next_state = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt     <= '0;
            byte_cnt     <= '0;
            hi_byte      <= '0;
            issued       <= 1'b0;
            spi_start    <= 1'b0;
            spi_data_in  <= 8'hFF;
            imu_ss_n     <= 1'b1;
            sample_data  <= '0;
            sample_idx   <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            ready        <= 1'b0;
`ifdef IMU_CFG_EN
            cfg_idx      <= '0;
`endif
        end else begin
            if (next_state != state)
                wait_cnt <= '0;
            else if (state inside {RESET_WAIT, CFG_GAP, RD_GAP})
                wait_cnt <= wait_cnt + CW'(1);

            spi_start <= issue;
            if (issue)          spi_data_in <= tx_byte;
            if (issue)          issued <= 1'b1;
            else if (byte_done) issued <= 1'b0;

            // Chip select follows the state being entered, so it moves on the transition edge.
            imu_ss_n <= !(next_state inside {CFG_ADDR, CFG_DATA, RD_ADDR, RD_BYTE});
            ready    <= (next_state == IDLE);

            if (state == RD_ADDR)
                byte_cnt <= '0;
            else if (state == RD_BYTE && byte_done && byte_cnt != LAST_BYTE)
                byte_cnt <= byte_cnt + 5'd1;

            if (state == RD_BYTE && byte_done && !byte_cnt[0])
                hi_byte <= spi_data_out;

            sample_valid <= (state == RD_BYTE) && byte_done && byte_cnt[0];
            frame_done   <= (state == RD_BYTE) && byte_done && (byte_cnt == LAST_BYTE);
            if (state == RD_BYTE && byte_done && byte_cnt[0]) begin
                sample_data <= {hi_byte, spi_data_out};
                sample_idx  <= byte_cnt[4:1];
            end

            if (tick && state != IDLE) overrun <= 1'b1;

`ifdef IMU_CFG_EN
            if (state == CFG_GAP && wait_done && cfg_idx != 2'd3)
                cfg_idx <= cfg_idx + 2'd1;
`endif
        end
    end

endmodule

// File: tb/tb_imu_spi_sched.sv
// Directed bench for imu_spi_sched with a behavioural SPI byte master; covers the
// IMU_CFG_EN build when that macro is defined.
module tb_imu_spi_sched;

    localparam int NW  = 3;
    localparam int IW  = 20;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_busy = 1'b0;
    logic        spi_new_data = 1'b0;
    logic [7:0]  spi_data_out = 8'h00;
    logic        imu_ss_n;
    logic [15:0] sample_data;
    logic [3:0]  sample_idx;
    logic        sample_valid;
    logic        frame_done;
    logic        overrun;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    int         busy_len = 0;
    int         remain = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         stamps[$];
    int         cyc = 0;
    int         extra_starts = 0;
    int         data_changes = 0;
    int         ss_rises = 0;
    int         fd_count = 0;
    logic       ss_prev = 1'b1;
    logic [3:0]  sv_idx[$];
    logic [15:0] sv_data[$];
    logic        sv_fd[$];

    imu_spi_sched #(
        .NUM_WORDS(NW), .BASE_ADDR(8'h3B), .INIT_WAIT(IW), .CS_GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
        .imu_ss_n(imu_ss_n), .sample_data(sample_data), .sample_idx(sample_idx),
        .sample_valid(sample_valid), .frame_done(frame_done),
        .overrun(overrun), .ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SPI byte master model: busy from the negedge after start for busy_len+1 cycles.
    always @(negedge clk) begin
        spi_new_data = 1'b0;
        if (!rst_n) begin
            spi_busy = 1'b0;
            remain   = 0;
        end else if (spi_busy) begin
            if (spi_start) extra_starts++;
            if (spi_data_in !== cur_byte) data_changes++;
            if (remain == 0) begin
                spi_busy     = 1'b0;
                spi_new_data = 1'b1;
                if (rx_q.size() > 0) spi_data_out = rx_q.pop_front();
                else                 spi_data_out = 8'h00;
            end else begin
                remain--;
            end
        end else if (spi_start) begin
            tx_log.push_back(spi_data_in);
            stamps.push_back(cyc);
            cur_byte = spi_data_in;
            spi_busy = 1'b1;
            remain   = busy_len;
        end
    end

    always @(negedge clk) begin
        if (imu_ss_n && !ss_prev) ss_rises++;
        ss_prev = imu_ss_n;
        if (sample_valid) begin
            sv_idx.push_back(sample_idx);
            sv_data.push_back(sample_data);
            sv_fd.push_back(frame_done);
        end
        if (frame_done) fd_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'h00;
    endfunction

    task automatic clear_logs();
        tx_log.delete();
        stamps.delete();
        sv_idx.delete();
        sv_data.delete();
        sv_fd.delete();
        ss_rises = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int max_cyc);
        int start_fd = fd_count;
        int n = 0;
        while (fd_count == start_fd && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_frame_seen"}, fd_count > start_fd, 1);
    endtask

    task automatic wait_ready(input string tag, input int max_cyc);
        int n = 0;
        while (!ready && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, ready, 1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] w0, w1, w2);
        logic [15:0] exp_w [3];
        exp_w[0] = w0;
        exp_w[1] = w1;
        exp_w[2] = w2;
        check({tag, "_count"}, sv_data.size(), NW);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s_idx%0d", tag, i), (i < sv_idx.size()) ? sv_idx[i] : 4'hF, i);
            check($sformatf("%s_word%0d", tag, i), (i < sv_data.size()) ? sv_data[i] : 16'hDEAD, exp_w[i]);
            check($sformatf("%s_done%0d", tag, i), (i < sv_fd.size()) ? sv_fd[i] : 1'bx, i == NW - 1);
        end
    endtask

    task automatic check_tx_frame(input string tag);
        check({tag, "_tx_count"}, tx_log.size(), 2 * NW + 1);
        check({tag, "_tx_addr"}, tx_at(0), 8'hBB);
        for (int i = 1; i <= 2 * NW; i++)
            check($sformatf("%s_tx_fill%0d", tag, i), tx_at(i), 8'hFF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, spi_start, 0);
        check({tag, "_din"}, spi_data_in, 8'hFF);
        check({tag, "_ss"}, imu_ss_n, 1);
        check({tag, "_data"}, sample_data, 0);
        check({tag, "_idx"}, sample_idx, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_ready"}, ready, 0);
    endtask

    task automatic check_power_up(input string tag);
`ifdef IMU_CFG_EN
        logic [7:0] cfg_exp [8] = '{8'h6B, 8'h80, 8'h6B, 8'h01, 8'h6A, 8'h10, 8'h1A, 8'h03};
        wait_ready({tag, "_ready"}, 3 * IW + 200);
        check({tag, "_cfg_count"}, tx_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_cfg_byte%0d", tag, i), tx_at(i), cfg_exp[i]);
        check({tag, "_cfg_ss_rises"}, ss_rises, 4);
        check({tag, "_cfg_init_gap"}, (stamps.size() > 2) && (stamps[2] - stamps[1] >= IW), 1);
        check({tag, "_ss_idle"}, imu_ss_n, 1);
`else
        repeat (IW) step();
        check({tag, "_ready_early"}, ready, 0);
        step();
        check({tag, "_ready"}, ready, 1);
        check({tag, "_no_spi"}, tx_log.size(), 0);
        check({tag, "_ss_idle"}, imu_ss_n, 1);
`endif
    endtask

    initial begin
        int n;

        // Reset values while rst_n is held low.
        repeat (3) step();
        check_reset_outputs("rst");
        clear_logs();
        rst_n = 1'b1;
        check_power_up("pwr");

        // Single frame with the tick-to-start latency.
        clear_logs();
        rx_q = '{8'hBB, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        pulse_tick();
        check("lat_start_c1", spi_start, 0);
        check("lat_ready_drop", ready, 0);
        check("lat_ss_low", imu_ss_n, 0);
        step();
        check("lat_start_c2", spi_start, 1);
        check("rd_addr_byte", spi_data_in, 8'hBB);
        wait_frame("f1", 200);
        repeat (GAP + 1) step();
        check_frame("f1", 16'h1234, 16'hABCD, 16'h00FF);
        check_tx_frame("f1");
        check("f1_ss_rises", ss_rises, 1);
        check("f1_ready", ready, 1);
        check("f1_no_overrun", overrun, 0);
        check("f1_hold", sample_data, 16'h00FF);

        // Second tick mid-frame: frame unchanged, overrun sticky.
        clear_logs();
        rx_q = '{8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pulse_tick();
        repeat (6) step();
        check("ov_mid_busy", ready, 0);
        pulse_tick();
        check("ov_flag", overrun, 1);
        wait_frame("ov", 200);
        repeat (GAP + 20) step();
        check_frame("ov", 16'h0102, 16'h0304, 16'h0506);
        check("ov_tx_count", tx_log.size(), 2 * NW + 1);
        check("ov_idle", ready, 1);

        // Slow SPI master: 20 busy cycles per byte.
        clear_logs();
        busy_len = 19;
        rx_q = '{8'hBB, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC0, 8'hDE};
        pulse_tick();
        wait_frame("busy", 600);
        repeat (GAP + 2) step();
        check_frame("busy", 16'hDEAD, 16'hBEEF, 16'hC0DE);
        check_tx_frame("busy");
        check("busy_extra_starts", extra_starts, 0);
        check("busy_data_stable", data_changes, 0);
        check("busy_overrun_sticky", overrun, 1);

        // Reset during the third byte of a frame.
        clear_logs();
        busy_len = 3;
        rx_q = '{8'hBB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_tick();
        n = 0;
        while (tx_log.size() < 3 && n < 200) begin
            step();
            n++;
        end
        check("mid_reached_byte3", tx_log.size(), 3);
        check("mid_ss_low", imu_ss_n, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        step();
        rx_q.delete();
        clear_logs();
        busy_len = 0;
        rst_n = 1'b1;
        check_power_up("rep");

        // Tick landing in the last RD_GAP cycle is an overrun, not a new frame.
        clear_logs();
        rx_q = '{8'hBB, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
        pulse_tick();
        n = 0;
        while (!frame_done && n < 200) begin
            step();
            n++;
        end
        check("x_frame_done", frame_done, 1);
        check("x_last_valid", sample_valid, 1);
        check("x_last_idx", sample_idx, NW - 1);
        check("x_last_data", sample_data, 16'h3CC3);
        check("x_ss_high", imu_ss_n, 1);
        repeat (GAP - 1) step();
        check("x_gap_ready", ready, 0);
        check("x_overrun_pre", overrun, 0);
        pulse_tick();
        check("x_ready", ready, 1);
        check("x_overrun", overrun, 1);
        repeat (20) step();
        check("x_ignored", tx_log.size(), 2 * NW + 1);
        check("x_still_idle", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
